// File: rtl/pe_pkg.sv
// Shared definitions for the output-stationary processing element.
// Holds the operand mode encoding, sticky-flag bit positions and a pointer-width helper.
// No logic, no latency, no backpressure.
package pe_pkg;

    // Per-term arithmetic interpretation of A and B
    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    // Bit positions inside the sticky flag register
    localparam int FLAG_OVF  = 0;
    localparam int FLAG_SAT  = 1;
    localparam int FLAG_DROP = 2;
    localparam int N_FLAGS   = 3;

    // Pointer width for a circular buffer; a one-entry buffer still needs a 1-bit pointer
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Result FIFO: circular buffer holding finished dot-product results.
// Latency: a push is visible on o_dat/o_vld from the next cycle; no bypass.
// Backpressure: push while full is accepted only with a same-edge pop, otherwise ignored.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (pointers and count)
//   i_push, i_push_dat    write request and data
//   i_pop                 read request (ignored when empty)
//   o_dat                 head entry, forced to 0 while empty
//   o_vld                 FIFO not empty
//   o_full                FIFO holds DEPTH entries
module pe_result_fifo
    import pe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_vld,
    output logic             o_full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;

    logic w_empty;
    logic w_pop;
    logic w_wr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // When full, the slot being written is the one being read this edge, so order holds
    assign w_wr    = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= ptr_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_next(r_rd);
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage is not reset; the empty mask on o_dat hides stale entries
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wr] <= i_push_dat;
        end
    end

    assign o_vld = !w_empty;
    assign o_dat = w_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/pe_os.sv
// Output-stationary MAC PE: forwards operands to its neighbour and accumulates A*B dot products.
// Latency: operands forwarded after 1 edge; a group result is valid 2 edges after its last term is sampled.
// Backpressure: results queue in a small FIFO popped by i_C_ready; a result arriving at a full FIFO is dropped (o_drop).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_en, i_clr                  pipeline enable, accumulator/valid clear
//   i_mode                       1 = signed, 0 = unsigned (per term)
//   i_valid, i_last, i_A, i_B    incoming term
//   o_valid, o_last, o_A, o_B    staged term forwarded to the neighbour
//   o_C, o_C_valid, i_C_ready    result stream from the FIFO head
//   o_ovf, o_sat, o_drop         sticky accumulator-wrap, saturation and drop flags
module pe_os
    import pe_pkg::*;
#(
    parameter int W         = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 0,
    parameter int RES_DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_mode,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [W-1:0]     i_A,
    input  logic [W-1:0]     i_B,
    output logic [W-1:0]     o_A,
    output logic [W-1:0]     o_B,
    output logic             o_valid,
    output logic             o_last,
    output logic [OUT_W-1:0] o_C,
    output logic             o_C_valid,
    input  logic             i_C_ready,
    output logic             o_ovf,
    output logic             o_sat,
    output logic             o_drop
);

    // Clamp bounds expressed in the accumulator width
    localparam logic [ACC_W-1:0] L_UMAX = {ACC_W{1'b1}} >> (ACC_W - OUT_W);
    localparam logic [ACC_W-1:0] L_SMAX = {ACC_W{1'b1}} >> (ACC_W - OUT_W + 1);
    localparam logic [ACC_W-1:0] L_SMIN = ~L_SMAX;

    // Operand stage
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_vld;
    logic               r_last;
    mode_e              r_mode;

    logic [ACC_W-1:0]   r_acc;
    logic [N_FLAGS-1:0] r_flags;

    logic [2*W-1:0]       w_a_ext;
    logic [2*W-1:0]       w_b_ext;
    logic [2*W-1:0]       w_prod;
    logic [ACC_W-1:0]     w_prod_sx;
    logic [ACC_W-1:0]     w_prod_zx;
    logic [ACC_W-1:0]     w_prod_ext;
    logic [ACC_W:0]       w_sum;
    logic [ACC_W-1:0]     w_acc_next;
    logic                 w_wrap;
    logic signed [ACC_W-1:0] w_shr_s;
    logic [ACC_W-1:0]     w_shr_u;
    logic [ACC_W-1:0]     w_shifted;
    logic [OUT_W-1:0]     w_res;
    logic                 w_clamp;
    logic                 w_acc_edge;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_drop;

    // Extending both operands to 2W before multiplying makes the low 2W product
    // bits correct for either interpretation with a single multiplier.
    assign w_a_ext = (r_mode == MODE_SIGNED) ? {{W{r_a[W-1]}}, r_a} : {{W{1'b0}}, r_a};
    assign w_b_ext = (r_mode == MODE_SIGNED) ? {{W{r_b[W-1]}}, r_b} : {{W{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_prod_sx  = ACC_W'($signed(w_prod));
    assign w_prod_zx  = ACC_W'(w_prod);
    assign w_prod_ext = (r_mode == MODE_SIGNED) ? w_prod_sx : w_prod_zx;

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_acc_next = w_sum[ACC_W-1:0];

    // Signed overflow: same-sign addends producing a result of the other sign
    assign w_wrap = (r_mode == MODE_SIGNED)
                  ? ((r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) && (w_acc_next[ACC_W-1] != r_acc[ACC_W-1]))
                  : w_sum[ACC_W];

    // Kept as separate nets so the arithmetic shift stays in a signed context
    assign w_shr_s   = $signed(w_acc_next) >>> SHIFT;
    assign w_shr_u   = w_acc_next >> SHIFT;
    assign w_shifted = (r_mode == MODE_SIGNED) ? w_shr_s : w_shr_u;

    always_comb begin
        w_clamp = 1'b0;
        w_res   = w_shifted[OUT_W-1:0];
        if (r_mode == MODE_SIGNED) begin
            if ($signed(w_shifted) > $signed(L_SMAX)) begin
                w_clamp = 1'b1;
                w_res   = L_SMAX[OUT_W-1:0];
            end else if ($signed(w_shifted) < $signed(L_SMIN)) begin
                w_clamp = 1'b1;
                w_res   = L_SMIN[OUT_W-1:0];
            end
        end else if (w_shifted > L_UMAX) begin
            w_clamp = 1'b1;
            w_res   = L_UMAX[OUT_W-1:0];
        end
    end

    // Clear wins over accumulation, so a cleared edge never pushes a result
    assign w_acc_edge = i_en && r_vld && !i_clr;
    assign w_push     = w_acc_edge && r_last;
    assign w_pop      = o_C_valid && i_C_ready;
    assign w_drop     = w_push && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_mode  <= MODE_UNSIGNED;
            r_acc   <= '0;
            r_flags <= '0;
        end else begin
            if (i_en) begin
                r_a    <= i_A;
                r_b    <= i_B;
                r_vld  <= i_valid;
                r_last <= i_last;
                r_mode <= mode_e'(i_mode);
            end
            if (i_clr) begin
                r_vld <= 1'b0;
                r_acc <= '0;
            end else if (w_acc_edge) begin
                // The last term restarts the accumulator for the next group
                r_acc <= r_last ? '0 : w_acc_next;
                if (w_wrap) begin
                    r_flags[FLAG_OVF] <= 1'b1;
                end
                if (w_push && w_clamp) begin
                    r_flags[FLAG_SAT] <= 1'b1;
                end
            end
            if (w_drop) begin
                r_flags[FLAG_DROP] <= 1'b1;
            end
        end
    end

    pe_result_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_push_dat (w_res),
        .i_pop      (w_pop),
        .o_dat      (o_C),
        .o_vld      (o_C_valid),
        .o_full     (w_full)
    );

    assign o_A     = r_a;
    assign o_B     = r_b;
    assign o_valid = r_vld;
    assign o_last  = r_last;
    assign o_ovf   = r_flags[FLAG_OVF];
    assign o_sat   = r_flags[FLAG_SAT];
    assign o_drop  = r_flags[FLAG_DROP];

endmodule

// File: tb/tb_pe_os.sv
module tb_pe_os;

    logic        i_clk = 1'b0;
    logic        i_rst, i_en, i_clr, i_mode, i_valid, i_last, i_C_ready;
    logic [15:0] i_A, i_B, o_A, o_B, o_C;
    logic        o_valid, o_last, o_C_valid, o_ovf, o_sat, o_drop;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] op_a [300];
    logic [15:0] op_b [300];
    bit          exp_sat;
    bit          exp_ovf;
    logic [15:0] exp_res;

    always #5 i_clk = ~i_clk;

    pe_os #(.W(16), .ACC_W(40), .OUT_W(16), .SHIFT(0), .RES_DEPTH(2)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_clr     (i_clr),
        .i_mode    (i_mode),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .i_A       (i_A),
        .i_B       (i_B),
        .o_A       (o_A),
        .o_B       (o_B),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .o_C       (o_C),
        .o_C_valid (o_C_valid),
        .i_C_ready (i_C_ready),
        .o_ovf     (o_ovf),
        .o_sat     (o_sat),
        .o_drop    (o_drop)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: whole-group sum with integer arithmetic, 40-bit wrap, then clamp to 16 bits.
    // Updates the sticky flag expectations as a side effect.
    function automatic logic [15:0] model_group(input int n, input bit md);
        longint acc = 0;
        longint a, b;
        logic [15:0] res;
        for (int i = 0; i < n; i++) begin
            a = longint'(op_a[i]);
            b = longint'(op_b[i]);
            if (md) begin
                if (a >= 32768) a -= 65536;
                if (b >= 32768) b -= 65536;
            end
            acc += a * b;
            if (md) begin
                if (acc > 64'sd549755813887) begin
                    exp_ovf = 1'b1;
                    acc -= 64'sd1099511627776;
                end else if (acc < -64'sd549755813888) begin
                    exp_ovf = 1'b1;
                    acc += 64'sd1099511627776;
                end
            end else if (acc >= 64'sd1099511627776) begin
                exp_ovf = 1'b1;
                acc -= 64'sd1099511627776;
            end
        end
        if (md) begin
            if (acc > 32767) begin
                res = 16'h7FFF; exp_sat = 1'b1;
            end else if (acc < -32768) begin
                res = 16'h8000; exp_sat = 1'b1;
            end else begin
                res = acc[15:0];
            end
        end else if (acc > 65535) begin
            res = 16'hFFFF; exp_sat = 1'b1;
        end else begin
            res = acc[15:0];
        end
        return res;
    endfunction

    // Drive n terms from op_a/op_b; optionally close the group and stall 3 cycles after term stall_at.
    task automatic send_terms(input int n, input bit md, input int stall_at, input bit close);
        for (int i = 0; i < n; i++) begin
            i_en    = 1'b1;
            i_A     = op_a[i];
            i_B     = op_b[i];
            i_mode  = md;
            i_valid = 1'b1;
            i_last  = close && (i == n - 1);
            tick();
            if (i == stall_at) begin
                i_en    = 1'b0;
                i_A     = ~op_a[i];
                i_B     = ~op_b[i];
                i_last  = ~i_last;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_A", o_A, op_a[i]);
                    check("stall_B", o_B, op_b[i]);
                    check("stall_valid", o_valid, 1'b1);
                    check("stall_last", o_last, close && (i == n - 1));
                end
                i_en = 1'b1;
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_A     = '0;
        i_B     = '0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] expv);
        for (int k = 0; k < 8 && !o_C_valid; k++) tick();
        check({tag, "_vld"}, o_C_valid, 1'b1);
        check(tag, o_C, expv);
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_clr = 1'b0; i_mode = 1'b0;
        i_valid = 1'b0; i_last = 1'b0; i_A = '0; i_B = '0; i_C_ready = 1'b1;
        exp_sat = 1'b0; exp_ovf = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        check("reset_outputs", {o_A, o_B, o_valid, o_last, o_C, o_C_valid, o_ovf, o_sat, o_drop}, '0);

        // Signed dot product with latency check
        op_a[0] = 16'd3; op_a[1] = 16'hFFFE; op_a[2] = 16'd5;
        op_b[0] = 16'd4; op_b[1] = 16'd7;    op_b[2] = 16'hFFFF;
        exp_res = model_group(3, 1'b1);
        send_terms(3, 1'b1, -1, 1'b1);
        check("dot_lat1_vld", o_C_valid, 1'b0);
        tick();
        check("dot_lat2_vld", o_C_valid, 1'b1);
        check("dot_C", o_C, exp_res);
        check("dot_flags", {o_ovf, o_sat, o_drop}, {exp_ovf, exp_sat, 1'b0});
        tick();

        // Unsigned at and above the clamp boundary
        op_a[0] = 16'hFFFF; op_b[0] = 16'd1;
        exp_res = model_group(1, 1'b0);
        send_terms(1, 1'b0, -1, 1'b1);
        expect_result("uns_max", exp_res);
        check("uns_max_sat", o_sat, exp_sat);
        tick();
        op_b[0] = 16'd2;
        exp_res = model_group(1, 1'b0);
        send_terms(1, 1'b0, -1, 1'b1);
        expect_result("uns_clamp", exp_res);
        check("uns_clamp_sat", o_sat, exp_sat);
        tick();

        // Signed positive and negative saturation
        op_a[0] = 16'h7FFF; op_a[1] = 16'h7FFF; op_b[0] = 16'h7FFF; op_b[1] = 16'h7FFF;
        exp_res = model_group(2, 1'b1);
        send_terms(2, 1'b1, -1, 1'b1);
        expect_result("sat_pos", exp_res);
        check("sat_pos_flag", o_sat, exp_sat);
        tick();
        op_a[0] = 16'h8000; op_a[1] = 16'h8000;
        exp_res = model_group(2, 1'b1);
        send_terms(2, 1'b1, -1, 1'b1);
        expect_result("sat_neg", exp_res);
        tick();

        // FIFO overflow with the consumer stalled
        i_C_ready = 1'b0;
        for (int g = 1; g <= 3; g++) begin
            op_a[0] = 16'(g); op_b[0] = 16'd1;
            send_terms(1, 1'b0, -1, 1'b1);
        end
        tick();
        check("ovfl_head", o_C, 16'd1);
        check("ovfl_vld", o_C_valid, 1'b1);
        check("ovfl_drop", o_drop, 1'b1);
        i_C_ready = 1'b1;
        tick();
        check("ovfl_pop2", o_C, 16'd2);
        tick();
        check("ovfl_empty_vld", o_C_valid, 1'b0);
        check("ovfl_empty_C", o_C, 16'd0);

        // Stall mid-group
        op_a[0] = 16'd10; op_a[1] = 16'd7; op_a[2] = 16'hFFFC;
        op_b[0] = 16'd2;  op_b[1] = 16'd3; op_b[2] = 16'd5;
        exp_res = model_group(3, 1'b1);
        send_terms(3, 1'b1, 1, 1'b1);
        expect_result("stall_C", exp_res);
        tick();

        // Reset mid-group with a queued result
        i_C_ready = 1'b0;
        op_a[0] = 16'd4; op_b[0] = 16'd4;
        send_terms(1, 1'b0, -1, 1'b1);
        op_a[0] = 16'd9; op_b[0] = 16'd9; op_a[1] = 16'd8; op_b[1] = 16'd8;
        send_terms(2, 1'b0, -1, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_sat = 1'b0; exp_ovf = 1'b0;
        check("rst_mid_outputs", {o_A, o_B, o_valid, o_last, o_C, o_C_valid, o_ovf, o_sat, o_drop}, '0);
        i_C_ready = 1'b1;
        op_a[0] = 16'd2; op_b[0] = 16'd3;
        exp_res = model_group(1, 1'b1);
        send_terms(1, 1'b1, -1, 1'b1);
        expect_result("rst_next", exp_res);
        tick();

        // Clear mid-group keeps the queued result
        i_C_ready = 1'b0;
        op_a[0] = 16'd5; op_b[0] = 16'd5;
        exp_res = model_group(1, 1'b0);
        send_terms(1, 1'b0, -1, 1'b1);
        tick();
        op_a[0] = 16'd7; op_b[0] = 16'd7; op_a[1] = 16'd6; op_b[1] = 16'd6;
        send_terms(2, 1'b0, -1, 1'b0);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        check("clr_queued", o_C, exp_res);
        check("clr_queued_vld", o_C_valid, 1'b1);
        op_a[0] = 16'd1; op_b[0] = 16'd7;
        send_terms(1, 1'b0, -1, 1'b1);
        i_C_ready = 1'b1;
        expect_result("clr_old", exp_res);
        exp_res = model_group(1, 1'b0);
        tick();
        expect_result("clr_new", exp_res);
        tick();

        // Randomised groups against the reference
        for (int g = 0; g < 25; g++) begin
            int n;
            int st;
            bit md;
            n  = $urandom_range(1, 4);
            md = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                op_a[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
                op_b[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            end
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            exp_res = model_group(n, md);
            send_terms(n, md, st, 1'b1);
            expect_result("rand_C", exp_res);
            check("rand_sat", o_sat, exp_sat);
            check("rand_ovf", o_ovf, exp_ovf);
            tick();
        end

        // Unsigned accumulator carry-out over a long group
        for (int i = 0; i < 257; i++) begin
            op_a[i] = 16'hFFFF;
            op_b[i] = 16'hFFFF;
        end
        exp_res = model_group(257, 1'b0);
        send_terms(257, 1'b0, -1, 1'b1);
        expect_result("wrap_C", exp_res);
        check("wrap_ovf", o_ovf, exp_ovf);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_os.md
PE_OS -- requirements
Module: pe_os

Interface
REQ-001 Parameter W, default 16: operand width of A and B.
REQ-002 Parameter ACC_W, default 40: accumulator width, at least 2*W.
REQ-003 Parameter OUT_W, default 16: result width on o_C, at most ACC_W.
REQ-004 Parameter SHIFT, default 0: right shift applied to the accumulator before saturation, less than ACC_W.
REQ-005 Parameter RES_DEPTH, default 2: result FIFO depth, at least 1.
REQ-006 Ports (name, direction, width, meaning):
 i_clk  in  1  sole clock, rising edge.
 i_rst  in  1  reset, synchronous, active-high.
 i_en  in  1  pipeline enable; low holds the operand stage and the accumulator.
 i_clr  in  1  synchronous clear of the accumulator and the operand-stage valid bit.
 i_mode  in  1  1 = signed two's complement, 0 = unsigned.
 i_valid  in  1  i_A/i_B carry a term.
 i_last  in  1  term is the last of its dot-product group.
 i_A, i_B  in  W  operands.
 o_A, o_B  out  W  operands forwarded to the neighbour PE.
 o_valid, o_last  out  1  forwarded i_valid and i_last.
 o_C  out  OUT_W  FIFO head result.
 o_C_valid  out  1  FIFO not empty.
 i_C_ready  in  1  consumer accepts o_C.
 o_ovf, o_sat, o_drop  out  1  sticky flags: accumulator wrap, output saturation, result dropped.

Function
REQ-007 Operand stage: when i_en=1, each edge registers i_A, i_B, i_valid, i_last and i_mode; when i_en=0 it holds; o_A/o_B/o_valid/o_last expose this register (latency 1).
REQ-008 MAC: when i_en=1 and the staged valid bit is 1, acc_next = acc + A*B, with the product sign- or zero-extended to ACC_W per the staged mode; acc updates at that edge and wraps modulo 2^ACC_W.
REQ-009 o_ovf is set on signed add overflow (mode 1) or carry-out (mode 0).
REQ-010 When the staged last bit is 1 at an accumulating edge: push res = sat(acc_next >> SHIFT) into the FIFO, and acc takes 0 at that edge rather than acc_next.
REQ-011 The shift is arithmetic for mode 1 and logical for mode 0.
REQ-012 sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1] for mode 1 and to [0, 2^OUT_W-1] for mode 0; any clamp sets o_sat.
REQ-013 Latency: o_C_valid rises 2 edges after i_last is sampled, given an empty FIFO and i_en=1; there is no bypass.
REQ-014 FIFO: pop occurs when o_C_valid and i_C_ready are both 1; pop is independent of i_en.
REQ-015 FIFO push when full: accepted only if a pop occurs on the same edge (count unchanged); otherwise the result is discarded, o_drop is set, and FIFO contents are unchanged.
REQ-016 Push on an empty FIFO: o_C_valid=1 from the next cycle. Push and pop on the same edge: order is preserved.
REQ-017 i_clr has priority over accumulation: acc becomes 0, the staged valid bit becomes 0, and the FIFO and flags are untouched.
REQ-018 Mode is taken per term; a mode change within a group is legal but yields a mixed sum, which is not checked.

Reset
REQ-019 When i_rst=1 at an edge: the operand stage, acc, FIFO count and pointers, and all flags become 0.
REQ-020 Outputs read 0 from the cycle after reset, including o_C (FIFO storage masked when empty).
REQ-021 i_rst overrides i_en and i_clr. Reset mid-group discards the partial sum; the next group starts from 0.

Structure
REQ-022 Mode encodings and flag bit positions belong in the shared package pe_pkg.
REQ-023 The result FIFO is a sub-module, pe_result_fifo, parametrised by width and depth, with synchronous active-high reset.
REQ-024 No other sub-modules; the multiplier and accumulator are inline.

Verification (W=16, ACC_W=40, OUT_W=16, SHIFT=0, RES_DEPTH=2)
REQ-025 Signed dot product: A={3,-2,5}, B={4,7,-1}, last on the third term -> o_C=0xFFF9 (-7), o_C_valid 2 cycles after the last term, no flags set.
REQ-026 Signed saturation: two terms of A=B=0x7FFF -> o_C=0x7FFF, o_sat=1; repeat with A=0x8000, B=0x7FFF -> o_C=0x8000.
REQ-027 Unsigned: single term A=0xFFFF, B=1 -> o_C=0xFFFF, o_sat=0; A=0xFFFF, B=2 -> o_C=0xFFFF, o_sat=1.
REQ-028 FIFO overflow: i_C_ready=0, single-term groups 1*1, 2*1, 3*1 -> o_C=1 held, o_drop=1 after the third; then i_C_ready=1 -> pops 1 then 2, then o_C_valid=0.
REQ-029 Stall: i_en=0 for 3 cycles mid-group -> o_A/o_B/o_valid held; the final result equals the unstalled result.
REQ-030 Reset and clear mid-group: i_rst for 1 cycle after 2 terms -> all outputs 0; the next group {2*3} yields 6; i_clr mid-group likewise discards the partial sum while preserving queued results.
